// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the IF/MEM requesters, the arbiter and the memory bus.
// The slave modport is the arbiter's view; the master modport is the environment's.
interface mem_bus_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_gnt;
  logic            if_rvalid;
  logic [DW-1:0]   if_rdata;
  logic            if_err;

  logic            mem_req;
  logic            mem_we;
  logic [DW/8-1:0] mem_wstrb;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [DW-1:0]   mem_rdata;
  logic            mem_err;

  logic            bus_req;
  logic            bus_we;
  logic [DW/8-1:0] bus_wstrb;
  logic [AW-1:0]   bus_addr;
  logic [DW-1:0]   bus_wdata;
  logic            bus_ack;
  logic [DW-1:0]   bus_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata, if_err,
    input  mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata, mem_err,
    output bus_req, bus_we, bus_wstrb, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    output mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_err,
    input  bus_req, bus_we, bus_wstrb, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between instruction fetch and load/store, MEM-priority
// with a starvation guard for IF and a watchdog that aborts unacknowledged transfers.
module mem_bus_arbiter #(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int TIMEOUT    = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_bus_arbiter_if.slave  bus_if
);
  localparam int TW = $clog2(TIMEOUT);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_IF  = 2'd1;
  localparam logic [1:0] S_WAIT_MEM = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            bus_req_q, bus_req_d;
  logic            bus_we_q, bus_we_d;
  logic [DW/8-1:0] bus_wstrb_q, bus_wstrb_d;
  logic [AW-1:0]   bus_addr_q, bus_addr_d;
  logic [DW-1:0]   bus_wdata_q, bus_wdata_d;
  logic            if_rvalid_q, if_rvalid_d, if_err_q, if_err_d;
  logic            mem_rvalid_q, mem_rvalid_d, mem_err_q, mem_err_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic            grant_if, grant_mem, done, timed_out;
  logic [DW-1:0]   done_data;

  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    tmo_d        = tmo_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_wstrb_d  = bus_wstrb_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    if_rvalid_d  = 1'b0;
    if_err_d     = 1'b0;
    if_rdata_d   = if_rdata_q;
    mem_rvalid_d = 1'b0;
    mem_err_d    = 1'b0;
    mem_rdata_d  = mem_rdata_q;
    grant_if     = 1'b0;
    grant_mem    = 1'b0;
    done         = 1'b0;
    timed_out    = 1'b0;
    done_data    = '0;

    case (state_q)
      S_IDLE: begin
        // MEM wins unless IF has already lost STARVE_MAX grants in a row.
        grant_mem = bus_if.mem_req && !(bus_if.if_req && starve_q == STARVE_LIM);
        grant_if  = bus_if.if_req && !grant_mem;
        if (grant_mem) begin
          state_d     = S_WAIT_MEM;
          bus_req_d   = 1'b1;
          tmo_d       = '0;
          bus_we_d    = bus_if.mem_we;
          bus_wstrb_d = bus_if.mem_wstrb;
          bus_addr_d  = bus_if.mem_addr;
          bus_wdata_d = bus_if.mem_wdata;
          if (bus_if.if_req && starve_q != STARVE_LIM) starve_d = starve_q + SW'(1);
        end else if (grant_if) begin
          state_d     = S_WAIT_IF;
          bus_req_d   = 1'b1;
          tmo_d       = '0;
          bus_we_d    = 1'b0;
          bus_wstrb_d = '0;
          bus_addr_d  = bus_if.if_addr;
          bus_wdata_d = '0;
          starve_d    = '0;
        end
      end
      S_WAIT_IF, S_WAIT_MEM: begin
        // An ack in the last watchdog cycle still completes normally.
        if (bus_if.bus_ack) begin
          done      = 1'b1;
          done_data = (state_q == S_WAIT_MEM && bus_we_q) ? '0 : bus_if.bus_rdata;
        end else if (tmo_q == TMO_LAST) begin
          done      = 1'b1;
          timed_out = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
        if (done) begin
          state_d   = S_IDLE;
          bus_req_d = 1'b0;
          tmo_d     = '0;
          if (state_q == S_WAIT_IF) begin
            if_rvalid_d = 1'b1;
            if_err_d    = timed_out;
            if_rdata_d  = done_data;
          end else begin
            mem_rvalid_d = 1'b1;
            mem_err_d    = timed_out;
            mem_rdata_d  = done_data;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      starve_q     <= '0;
      tmo_q        <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_wstrb_q  <= '0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      if_rvalid_q  <= 1'b0;
      if_err_q     <= 1'b0;
      if_rdata_q   <= '0;
      mem_rvalid_q <= 1'b0;
      mem_err_q    <= 1'b0;
      mem_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      tmo_q        <= tmo_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_wstrb_q  <= bus_wstrb_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      if_rvalid_q  <= if_rvalid_d;
      if_err_q     <= if_err_d;
      if_rdata_q   <= if_rdata_d;
      mem_rvalid_q <= mem_rvalid_d;
      mem_err_q    <= mem_err_d;
      mem_rdata_q  <= mem_rdata_d;
    end
  end

  assign bus_if.if_gnt     = grant_if;
  assign bus_if.mem_gnt    = grant_mem;
  assign bus_if.if_rvalid  = if_rvalid_q;
  assign bus_if.if_rdata   = if_rdata_q;
  assign bus_if.if_err     = if_err_q;
  assign bus_if.mem_rvalid = mem_rvalid_q;
  assign bus_if.mem_rdata  = mem_rdata_q;
  assign bus_if.mem_err    = mem_err_q;
  assign bus_if.bus_req    = bus_req_q;
  assign bus_if.bus_we     = bus_we_q;
  assign bus_if.bus_wstrb  = bus_wstrb_q;
  assign bus_if.bus_addr   = bus_addr_q;
  assign bus_if.bus_wdata  = bus_wdata_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a transaction-level reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_mem_bus_arbiter;
  localparam int TIMEOUT    = 16;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  mem_bus_arbiter_if #(.DW(32), .AW(32)) bif ();

  mem_bus_arbiter #(.DW(32), .AW(32), .TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_if(bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Memory slave: acks on the ack_at-th consecutive bus_req cycle (0 = never).
  int          ack_at  = 0;
  logic [31:0] ack_data = '0;
  int          req_cyc = 0;
  always @(posedge clk) begin
    #1;
    if (bif.bus_req) req_cyc++;
    else req_cyc = 0;
    bif.bus_ack   = (ack_at != 0) && bif.bus_req && (req_cyc == ack_at);
    bif.bus_rdata = bif.bus_ack ? ack_data : (32'hA5A5_0000 ^ 32'(req_cyc));
  end

  // Reference model: one outstanding transfer, aged in bus_req cycles.
  bit          m_busy, m_is_mem;
  int          m_age, m_starve;
  logic        e_we;
  logic [3:0]  e_wstrb;
  logic [31:0] e_addr, e_wdata;
  logic        e_irv, e_ierr, e_mrv, e_merr;
  logic [31:0] e_ird, e_mrd;

  function automatic bit mem_wins(input logic mreq, input logic ireq, input int starve);
    return mreq && !(ireq && starve == STARVE_MAX);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_is_mem = 0; m_age = 0; m_starve = 0;
      e_irv = 0; e_ierr = 0; e_mrv = 0; e_merr = 0; e_ird = 0; e_mrd = 0;
    end else begin
      e_irv = 0; e_ierr = 0; e_mrv = 0; e_merr = 0;
      if (m_busy) begin
        m_age++;
        if (bif.bus_ack || m_age == TIMEOUT) begin
          logic [31:0] rd;
          logic        to;
          to = !bif.bus_ack;
          rd = (to || (m_is_mem && e_we)) ? 32'h0 : bif.bus_rdata;
          m_busy = 0;
          if (m_is_mem) begin e_mrv = 1; e_merr = to; e_mrd = rd; end
          else          begin e_irv = 1; e_ierr = to; e_ird = rd; end
        end
      end else if (mem_wins(bif.mem_req, bif.if_req, m_starve)) begin
        m_busy = 1; m_is_mem = 1; m_age = 0;
        e_we = bif.mem_we; e_wstrb = bif.mem_wstrb; e_addr = bif.mem_addr; e_wdata = bif.mem_wdata;
        if (bif.if_req && m_starve < STARVE_MAX) m_starve++;
      end else if (bif.if_req) begin
        m_busy = 1; m_is_mem = 0; m_age = 0;
        e_we = 0; e_wstrb = 0; e_addr = bif.if_addr; e_wdata = 0;
        m_starve = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      bit eg_m, eg_i;
      eg_m = !m_busy && mem_wins(bif.mem_req, bif.if_req, m_starve);
      eg_i = !m_busy && bif.if_req && !eg_m;
      chk("mdl mem_gnt", bif.mem_gnt, eg_m);
      chk("mdl if_gnt", bif.if_gnt, eg_i);
      chk("mdl bus_req", bif.bus_req, m_busy);
      chk("mdl if_rvalid", bif.if_rvalid, e_irv);
      chk("mdl if_err", bif.if_err, e_ierr);
      chk("mdl if_rdata", bif.if_rdata, e_ird);
      chk("mdl mem_rvalid", bif.mem_rvalid, e_mrv);
      chk("mdl mem_err", bif.mem_err, e_merr);
      chk("mdl mem_rdata", bif.mem_rdata, e_mrd);
      if (m_busy) begin
        chk("mdl bus_we", bif.bus_we, e_we);
        chk("mdl bus_wstrb", bif.bus_wstrb, e_wstrb);
        chk("mdl bus_addr", bif.bus_addr, e_addr);
        if (m_is_mem) chk("mdl bus_wdata", bif.bus_wdata, e_wdata);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int          cnt, ng, rv;
    logic [5:0]  order;
    rst_n = 1'b0;
    bif.if_req = 0; bif.if_addr = 0;
    bif.mem_req = 0; bif.mem_we = 0; bif.mem_wstrb = 0; bif.mem_addr = 0; bif.mem_wdata = 0;
    bif.bus_ack = 0; bif.bus_rdata = 0;
    repeat (3) adv();
    smp();
    chk("rst bus_req", bif.bus_req, 0);
    chk("rst if_rvalid", bif.if_rvalid, 0);
    chk("rst mem_rvalid", bif.mem_rvalid, 0);
    chk("rst bus_addr", bif.bus_addr, 0);
    chk("rst if_rdata", bif.if_rdata, 0);
    chk("rst mem_rdata", bif.mem_rdata, 0);
    mon_en = 1'b1;

    // IF fetch alone
    adv(); rst_n = 1'b1;
    bif.if_req = 1; bif.if_addr = 32'h100; ack_at = 2; ack_data = 32'h13;
    smp(); chk("fetch if_gnt c0", bif.if_gnt, 1);
    adv(); bif.if_req = 0;
    smp(); chk("fetch bus_req c1", bif.bus_req, 1); chk("fetch bus_addr", bif.bus_addr, 32'h100);
    chk("fetch bus_we", bif.bus_we, 0);
    adv(); smp(); chk("fetch bus_req c2", bif.bus_req, 1);
    adv(); smp(); chk("fetch if_rvalid c3", bif.if_rvalid, 1);
    chk("fetch if_rdata", bif.if_rdata, 32'h13); chk("fetch if_err", bif.if_err, 0);
    chk("fetch bus_req c3", bif.bus_req, 0);
    adv(); smp(); chk("fetch if_rvalid c4", bif.if_rvalid, 0); chk("fetch rdata hold", bif.if_rdata, 32'h13);

    // Store
    adv(); bif.mem_req = 1; bif.mem_we = 1; bif.mem_wstrb = 4'hF; bif.mem_addr = 32'h2000;
    bif.mem_wdata = 32'hDEADBEEF; ack_at = 1; ack_data = 32'h12345678;
    smp(); chk("store mem_gnt", bif.mem_gnt, 1);
    adv(); bif.mem_req = 0; bif.mem_we = 0; bif.mem_wstrb = 0; bif.mem_addr = 0; bif.mem_wdata = 0;
    smp(); chk("store bus_we", bif.bus_we, 1); chk("store bus_wdata", bif.bus_wdata, 32'hDEADBEEF);
    chk("store bus_addr", bif.bus_addr, 32'h2000); chk("store bus_wstrb", bif.bus_wstrb, 4'hF);
    adv(); smp(); chk("store mem_rvalid", bif.mem_rvalid, 1); chk("store mem_rdata", bif.mem_rdata, 0);
    chk("store mem_err", bif.mem_err, 0);
    adv(); smp(); chk("store rvalid once", bif.mem_rvalid, 0);

    // Simultaneous requests: 4 MEM, then IF, then MEM again once the count clears
    adv(); bif.if_req = 1; bif.if_addr = 32'h104; bif.mem_req = 1; bif.mem_addr = 32'h3000;
    ack_at = 1; ack_data = 32'h77;
    ng = 0; order = '0;
    for (int c = 0; c < 60 && ng < 6; c++) begin
      smp();
      if (bif.mem_gnt) begin order[5-ng] = 1'b1; ng++; end
      else if (bif.if_gnt) begin order[5-ng] = 1'b0; ng++; end
      if (ng < 6) adv();
    end
    chk("starve grant count", ng, 6);
    chk("starve grant order", order, 6'b111101);
    adv(); bif.if_req = 0; bif.mem_req = 0;
    repeat (3) adv();

    // Timeout on a load; IF granted in the rvalid cycle
    bif.mem_req = 1; bif.mem_we = 0; bif.mem_addr = 32'h4000; ack_at = 0;
    smp(); chk("tmo mem_gnt", bif.mem_gnt, 1);
    adv(); bif.mem_req = 0; bif.if_req = 1; bif.if_addr = 32'h200;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      smp();
      if (!bif.bus_req) break;
      cnt++;
      adv();
      if (cnt == 5) begin ack_at = 2; ack_data = 32'hCAFE; end
    end
    chk("tmo bus_req cycles", cnt, 16);
    chk("tmo mem_rvalid", bif.mem_rvalid, 1); chk("tmo mem_err", bif.mem_err, 1);
    chk("tmo mem_rdata", bif.mem_rdata, 0); chk("tmo if_gnt in rvalid", bif.if_gnt, 1);
    adv(); bif.if_req = 0;
    adv(); adv(); smp();
    chk("tmo follow if_rvalid", bif.if_rvalid, 1); chk("tmo follow if_rdata", bif.if_rdata, 32'hCAFE);

    // Ack on the final watchdog cycle
    adv(); bif.mem_req = 1; bif.mem_addr = 32'h5000; ack_at = 16; ack_data = 32'h55;
    smp(); chk("last mem_gnt", bif.mem_gnt, 1);
    adv(); bif.mem_req = 0;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      smp();
      if (!bif.bus_req) break;
      cnt++;
      adv();
    end
    chk("last bus_req cycles", cnt, 16);
    chk("last mem_rvalid", bif.mem_rvalid, 1); chk("last mem_err", bif.mem_err, 0);
    chk("last mem_rdata", bif.mem_rdata, 32'h55);

    // Reset in the middle of a transfer
    adv(); bif.mem_req = 1; bif.mem_addr = 32'h6000; ack_at = 0;
    smp(); chk("rmid mem_gnt", bif.mem_gnt, 1);
    adv(); bif.mem_req = 0;
    adv(); adv(); rst_n = 1'b0;
    smp(); chk("rmid bus_req before", bif.bus_req, 1);
    adv(); rst_n = 1'b1;
    smp(); chk("rmid bus_req after", bif.bus_req, 0);
    rv = 0;
    repeat (20) begin
      adv(); smp();
      if (bif.mem_rvalid || bif.if_rvalid) rv++;
    end
    chk("rmid no rvalid", rv, 0);
    adv(); bif.if_req = 1; bif.if_addr = 32'h300; ack_at = 2; ack_data = 32'h1234;
    smp(); chk("rmid new if_gnt", bif.if_gnt, 1);
    adv(); bif.if_req = 0;
    adv(); adv(); smp();
    chk("rmid new if_rvalid", bif.if_rvalid, 1); chk("rmid new if_rdata", bif.if_rdata, 32'h1234);
    adv(); adv();
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
